// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared types and defaults for the program sequencer run control
package ps_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BOOT   = 3'd1,
    RUN    = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ps_run_control.sv
// rtl/ps_run_control.sv - run/halt/step/breakpoint control for the program sequencer
// Owns sequencer sync_reset, pc hold, the zero flag and the executed-instruction counter.
module ps_run_control
  import ps_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              soft_reset,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pm_addr,
  input  logic              alu_we,
  input  logic              alu_zero,
  output logic              sync_reset,
  output logic              ps_hold,
  output logic              dont_jmp,
  output logic              bp_hit,
  output logic [2:0]        run_state,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);

  run_state_t    state;
  logic [BW-1:0] boot_cnt;
  logic          boot_entry;
  logic          executing;
  logic          bp_match;

  assign executing = (state == RUN) || (state == STEP);
  assign bp_match  = bp_en && (pm_addr == bp_addr);

  // soft_reset is deliberately not a boot cause from IDLE or while already booting
  always_comb begin
    boot_entry = 1'b0;
    case (state)
      IDLE:              boot_entry = start;
      RUN, HALTED, STEP: boot_entry = soft_reset;
      default:           boot_entry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      boot_cnt <= '0;
      dont_jmp <= 1'b0;
      bp_hit   <= 1'b0;
    end else begin
      if (executing && alu_we) begin
        dont_jmp <= alu_zero;
      end
      if (boot_entry) begin
        state    <= BOOT;
        boot_cnt <= '0;
        dont_jmp <= 1'b0;
        bp_hit   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          BOOT: begin
            if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
              state <= RUN;
            end else begin
              boot_cnt <= boot_cnt + BW'(1);
            end
          end
          RUN: begin
            if (halt_req) begin
              state  <= HALTED;
              bp_hit <= 1'b0;
            end else if (bp_match) begin
              state  <= HALTED;
              bp_hit <= 1'b1;
            end
          end
          HALTED: begin
            if (start) begin
              state <= RUN;
            end else if (step_req) begin
              state <= STEP;
            end
          end
          STEP:    state <= HALTED;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sync_reset = (state == IDLE) || (state == BOOT);
  assign ps_hold    = (state == IDLE) || (state == HALTED);
  assign run_state  = state;

  sat_counter #(.W(CNT_W)) u_instr_count (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (boot_entry),
    .enable  (executing),
    .count   (instr_count)
  );

endmodule

// File: tb/tb_ps_run_control.sv
// tb/tb_ps_run_control.sv - directed and random checks of ps_run_control against a behavioural model
module tb_ps_run_control;

  logic       clk = 1'b0;
  logic       reset_n, start, halt_req, step_req, soft_reset, bp_en, alu_we, alu_zero;
  logic [7:0] bp_addr, pm_addr;

  logic        sync_reset_a, ps_hold_a, dont_jmp_a, bp_hit_a;
  logic [2:0]  run_state_a;
  logic [15:0] cnt_a;
  logic        sync_reset_b, ps_hold_b, dont_jmp_b, bp_hit_b;
  logic [2:0]  run_state_b;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  // model: mode numbers are the published run_state codes, count is unbounded
  int m_st, m_left, m_cnt, m_zero, m_bp, m_pc;

  always #5 clk = ~clk;

  ps_run_control #(.ADDR_W(8), .CNT_W(16), .BOOT_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .step_req(step_req), .soft_reset(soft_reset), .bp_en(bp_en),
    .bp_addr(bp_addr), .pm_addr(pm_addr), .alu_we(alu_we), .alu_zero(alu_zero),
    .sync_reset(sync_reset_a), .ps_hold(ps_hold_a), .dont_jmp(dont_jmp_a),
    .bp_hit(bp_hit_a), .run_state(run_state_a), .instr_count(cnt_a)
  );

  ps_run_control #(.ADDR_W(8), .CNT_W(4), .BOOT_CYCLES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .step_req(step_req), .soft_reset(soft_reset), .bp_en(bp_en),
    .bp_addr(bp_addr), .pm_addr(pm_addr), .alu_we(alu_we), .alu_zero(alu_zero),
    .sync_reset(sync_reset_b), .ps_hold(ps_hold_b), .dont_jmp(dont_jmp_b),
    .bp_hit(bp_hit_b), .run_state(run_state_b), .instr_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_pm();
    return (m_st <= 1) ? 0 : ((m_pc + 1) % 256);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = 0; m_cnt = 0; m_zero = 0; m_bp = 0; m_pc = 0;
  endtask

  task automatic model_step();
    int  st;
    bit  enter;
    st    = m_st;
    enter = 1'b0;
    if (st == 2 || st == 4) begin
      m_pc  = pm_addr;
      m_cnt = m_cnt + 1;
      if (alu_we) m_zero = alu_zero;
    end else if (st <= 1) begin
      m_pc = 0;
    end
    case (st)
      0: enter = start;
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = 2;
      end
      2: begin
        if (soft_reset) enter = 1'b1;
        else if (halt_req) begin m_st = 3; m_bp = 0; end
        else if (bp_en && pm_addr == bp_addr) begin m_st = 3; m_bp = 1; end
      end
      3: begin
        if (soft_reset) enter = 1'b1;
        else if (start) m_st = 2;
        else if (step_req) m_st = 4;
      end
      default: begin
        if (soft_reset) enter = 1'b1;
        else m_st = 3;
      end
    endcase
    if (enter) begin
      m_st = 1; m_left = 2; m_cnt = 0; m_zero = 0; m_bp = 0;
    end
  endtask

  task automatic check_all();
    check("a.state", run_state_a, m_st);
    check("a.sync_reset", sync_reset_a, (m_st <= 1) ? 1 : 0);
    check("a.ps_hold", ps_hold_a, (m_st == 0 || m_st == 3) ? 1 : 0);
    check("a.dont_jmp", dont_jmp_a, m_zero);
    check("a.bp_hit", bp_hit_a, m_bp);
    check("a.count", cnt_a, sat(m_cnt, 65535));
    check("b.state", run_state_b, m_st);
    check("b.ps_hold", ps_hold_b, (m_st == 0 || m_st == 3) ? 1 : 0);
    check("b.sync_reset", sync_reset_b, (m_st <= 1) ? 1 : 0);
    check("b.flags", {dont_jmp_b, bp_hit_b}, {m_zero[0], m_bp[0]});
    check("b.count", cnt_b, sat(m_cnt, 15));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n) model_step();
    else model_reset();
    check_all();
    pm_addr = 8'(next_pm());
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_req = 1'b0; soft_reset = 1'b0;
    bp_en = 1'b0; bp_addr = 8'h00; pm_addr = 8'h00; alu_we = 1'b0; alu_zero = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst.state", run_state_a, 0);
    check("rst.sync_reset", sync_reset_a, 1);
    check("rst.ps_hold", ps_hold_a, 1);
    check("rst.count", cnt_a, 0);
    reset_n = 1'b1;
    tick();

    // boot sequence, then run from 0 into a breakpoint at 5
    bp_en = 1'b1; bp_addr = 8'h05; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1.boot0", run_state_a, 1);
    check("t1.boot0_sync", sync_reset_a, 1);
    tick();
    check("t1.boot1", run_state_a, 1);
    tick();
    check("t1.run", run_state_a, 2);
    check("t1.run_sync", sync_reset_a, 0);
    tick();
    check("t1.count1", cnt_a, 1);
    for (int i = 0; i < 20 && run_state_a != 3'd3; i++) tick();
    check("t2.halted", run_state_a, 3);
    check("t2.bp_hit", bp_hit_a, 1);
    check("t2.ps_hold", ps_hold_a, 1);
    check("t2.count", cnt_a, 5);
    repeat (10) tick();
    check("t2.count_frozen", cnt_a, 5);

    for (int s = 0; s < 3; s++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      check("t3.in_step", run_state_a, 4);
      tick();
      check("t3.back_halted", run_state_a, 3);
      tick();
    end
    check("t3.count", cnt_a, 8);
    check("t3.bp_hit", bp_hit_a, 1);

    // zero flag updates only while executing
    bp_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; alu_we = 1'b1; alu_zero = 1'b1;
    tick();
    alu_we = 1'b0; alu_zero = 1'b0;
    repeat (2) tick();
    check("t4.dont_jmp_set", dont_jmp_a, 1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t4.halted", run_state_a, 3);
    alu_we = 1'b1; alu_zero = 1'b0;
    tick();
    alu_we = 1'b0;
    check("t4.dont_jmp_held", dont_jmp_a, 1);

    // halt_req outranks a breakpoint; soft_reset outranks both
    start = 1'b1;
    tick();
    start = 1'b0; bp_en = 1'b1; bp_addr = pm_addr; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("t5.halted", run_state_a, 3);
    check("t5.bp_hit", bp_hit_a, 0);
    start = 1'b1;
    tick();
    start = 1'b0; bp_addr = pm_addr; halt_req = 1'b1; soft_reset = 1'b1;
    tick();
    halt_req = 1'b0; soft_reset = 1'b0; bp_en = 1'b0;
    check("t5.boot", run_state_a, 1);
    check("t5.count", cnt_a, 0);
    check("t5.dont_jmp", dont_jmp_a, 0);

    // narrow counter saturation, then async reset in the middle of BOOT
    repeat (22) tick();
    check("t6.sat", cnt_b, 15);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("t6.boot", run_state_a, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6.async_state", run_state_a, 0);
    check("t6.async_sync", sync_reset_a, 1);
    check("t6.async_hold", ps_hold_a, 1);
    check("t6.async_b_state", run_state_b, 0);
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom % 8) == 0;
      halt_req   = ($urandom % 10) == 0;
      step_req   = ($urandom % 5) == 0;
      soft_reset = ($urandom % 40) == 0;
      bp_en      = $urandom % 2;
      bp_addr    = ($urandom % 2) ? pm_addr + 8'($urandom_range(0, 3)) : 8'($urandom);
      alu_we     = $urandom % 2;
      alu_zero   = $urandom % 2;
      reset_n    = ($urandom % 400) != 0;
      tick();
      reset_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps_run_control.md
Name: ps_run_control

Overview:
Run/halt/step controller for the program sequencer and program memory fetch path.
- Owns the sequencer's sync_reset and a PC-hold request.
- Owns the zero flag that feeds the sequencer's dont_jmp input.
- Provides a PC breakpoint, single-step, and a saturating executed-instruction counter for debug.
- Sits between the top-level debug/control inputs and the program sequencer; the sequencer holds pc when ps_hold=1.

Parameters:
ADDR_W, 8, program memory address width (pc / pm_addr / bp_addr).
CNT_W, 16, width of the executed-instruction counter.
BOOT_CYCLES, 2, cycles sync_reset is held after a boot request (minimum 1).

Ports:
clk  input  1  system clock, all state changes on its rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  level/pulse: leave IDLE, or resume from HALTED
halt_req  input  1  request halt while running
step_req  input  1  pulse: execute exactly one instruction while HALTED
soft_reset  input  1  restart program from address 0 (via BOOT)
bp_en  input  1  breakpoint enable
bp_addr  input  ADDR_W  breakpoint address
pm_addr  input  ADDR_W  next fetch address from the program sequencer
alu_we  input  1  ALU result write strobe from the instruction decoder
alu_zero  input  1  ALU result == 0
sync_reset  output  1  to sequencer; forces pm_addr=0
ps_hold  output  1  to sequencer; pc holds its value
dont_jmp  output  1  registered zero flag; blocks jmp_nz
bp_hit  output  1  sticky: last halt was caused by the breakpoint
run_state  output  3  encoded FSM state
instr_count  output  CNT_W  instructions executed since last BOOT, saturating

Behaviour:
- Async reset (reset_n=0):
  - State = IDLE.
  - sync_reset=1, ps_hold=1, dont_jmp=0, bp_hit=0, instr_count=0.
- States and run_state encoding: IDLE=0, BOOT=1, RUN=2, HALTED=3, STEP=4. sync_reset and ps_hold are decoded from the registered state only (no input-to-output combinational path).
- IDLE:
  - Outputs: sync_reset=1, ps_hold=1.
  - start moves to BOOT.
- BOOT:
  - Outputs: sync_reset=1, ps_hold=0.
  - Lasts exactly BOOT_CYCLES cycles, then moves to RUN.
  - On entry, clears instr_count, dont_jmp and bp_hit.
- RUN:
  - Outputs: sync_reset=0, ps_hold=0.
  - instr_count increments every cycle.
  - Exit priority, highest first:
    1. soft_reset moves to BOOT.
    2. halt_req moves to HALTED, bp_hit=0.
    3. bp_en && pm_addr==bp_addr moves to HALTED, bp_hit=1.
  - On a breakpoint, pc loads bp_addr on the match edge and then holds, so pc==bp_addr while HALTED. The instruction at bp_addr has been fetched but not counted.
- HALTED:
  - Outputs: sync_reset=0, ps_hold=1. instr_count frozen.
  - Transition priority: soft_reset, then start (to RUN), then step_req (to STEP).
  - halt_req is ignored.
- STEP:
  - Exactly one cycle with ps_hold=0; instr_count increments by 1.
  - Returns to HALTED unconditionally. Breakpoint match and halt_req are ignored in STEP.
  - soft_reset in STEP moves to BOOT.
- soft_reset in IDLE is ignored. start must be used.
- Zero flag:
  - Updated on clk edge when alu_we=1 and state is RUN or STEP: dont_jmp <= alu_zero.
  - Otherwise it holds. It is cleared in BOOT.
- instr_count:
  - Saturates at all-ones; no wrap.
  - Cleared only by reset or BOOT entry.
- bp_hit is sticky until the next halt cause or BOOT.
- Resume from a breakpoint: the first RUN cycle sees pm_addr = pc+1, so no immediate re-halt unless the breakpoint equals that address.
- Async reset mid-operation returns to IDLE immediately regardless of state or BOOT counter value.

Decomposition:
- Shared package ps_pkg:
  - typedef enum logic [2:0] run_state_t (IDLE, BOOT, RUN, HALTED, STEP).
  - Default ADDR_W/CNT_W constants.
- One sub-module is natural: sat_counter (CNT_W, clear, enable, saturating), reused for instr_count.
- The BOOT cycle counter stays inline.

Test Plan:
1. Reset, then start=1 for one cycle. Expect IDLE, then BOOT for 2 cycles with sync_reset=1, then RUN with sync_reset=0. instr_count counts 1,2,3… from the first RUN cycle.
2. bp_en=1, bp_addr=8'h05, program running from 0. Expect HALTED with pc=8'h05, bp_hit=1, ps_hold=1, instr_count=5; instr_count stays 5 for 10 idle cycles.
3. From scenario 2, pulse step_req three times, spaced. Expect 3 single STEP cycles, pc=8'h08, instr_count=8, breakpoint not retriggered.
4. In RUN, alu_we=1 with alu_zero=1, then alu_we=0 with alu_zero=0. Expect dont_jmp=1 and held. Halt, then alu_we=1 with alu_zero=0 while HALTED: expect dont_jmp still 1.
5. halt_req and a breakpoint match in the same RUN cycle. Expect HALTED with bp_hit=0. soft_reset asserted in that cycle instead: expect BOOT, instr_count=0, dont_jmp=0.
6. CNT_W=4 instance run 20 cycles: instr_count saturates at 4'hF. Drive reset_n low mid-BOOT: expect IDLE and all outputs at reset values asynchronously.
